led_pattern_sequencer: RTL and testbench

- Controller for the board's 8-LED bank. Replaces the fixed free-running shift chase with a command-driven sequencer.
- A programmable prescaler generates step ticks. The block advances one of four pattern modes on each tick.
- New mode, period and seed commands arrive over a valid/ready interface, driven by a host/CPU register block or a top-level button decoder.
- `leds` feeds the top-level LED pins directly.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_tick_gen.sv | 40 ++++
 rtl/led_pattern_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: pattern mode encoding, sequencer FSM states, bounce direction constants.
package led_pkg;

  // Encoding matches the cmd_mode port values.
  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    BLINK  = 2'd2,
    STATIC = 2'd3
  } mode_e;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: emits one tick per (period+1) enabled clocks.
// Latency: tick is combinational from the counter; the counter wraps in the tick cycle.
// Backpressure: enable=0 freezes the counter; clear forces it back to 0.
//
// Ports:
//   iCE_CLK, iCE_RST_N - clock, async active-low reset
//   period             - tick period, compared unsigned against the counter
//   enable             - counter advances only while high
//   clear              - synchronous restart from 0 (takes priority over enable)
//   tick               - high in the enabled cycle where counter >= period
module led_tick_gen #(
  parameter int CNT_W = 32
) (
  input  logic             iCE_CLK,
  input  logic             iCE_RST_N,
  input  logic [CNT_W-1:0] period,
  input  logic             enable,
  input  logic             clear,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] counter;

  // counter never exceeds period, so the increment cannot overflow.
  assign tick = enable && (counter >= period);

  always_ff @(posedge iCE_CLK or negedge iCE_RST_N) begin
    if (!iCE_RST_N) begin
      counter <= '0;
    end else if (clear) begin
      counter <= '0;
    end else if (enable) begin
      if (tick) counter <= '0;
      else      counter <= counter + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Command-driven sequencer for the LED bank: chase, bounce, blink or static patterns.
// Latency: leds shows the new mode's initial value one clock after the accept edge (LOAD).
// Backpressure: cmd_ready is low for the single LOAD cycle after each accepted command.
//
// Ports:
//   iCE_CLK, iCE_RST_N            - clock, async active-low reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_mode/cmd_period/cmd_pattern - command payload, sampled only on accept
//   pause                         - level, freezes prescaler and pattern
//   leds                          - registered LED drive
//   step_pulse                    - registered strobe, high when leds takes a stepped value
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int          NUM_LEDS       = 8,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 600000
) (
  input  logic                iCE_CLK,
  input  logic                iCE_RST_N,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [CNT_W-1:0]    cmd_period,
  input  logic [NUM_LEDS-1:0] cmd_pattern,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step_pulse
);

  localparam logic [NUM_LEDS-1:0] LED_BIT0 = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [CNT_W-1:0]    period_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic                dir_q, dir_d;
  logic [NUM_LEDS-1:0] leds_d;
  logic                step_d;

  logic                accept;
  logic                tick_en;
  logic                tick;
  logic                step;
  logic [NUM_LEDS-1:0] init_val;
  logic [NUM_LEDS-1:0] shifted;

  assign accept  = cmd_valid && cmd_ready;
  assign tick_en = (state_q == RUN) && !pause;
  // A command in the same cycle as a tick wins; the tick is simply lost.
  assign step    = tick && !accept;

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .iCE_CLK   (iCE_CLK),
    .iCE_RST_N (iCE_RST_N),
    .period    (period_q),
    .enable    (tick_en),
    .clear     (state_q == LOAD),
    .tick      (tick)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge iCE_CLK or negedge iCE_RST_N) begin
    if (!iCE_RST_N) state_q <= LOAD;
    else            state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = RUN;
      RUN:     if (accept) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      RUN:     cmd_ready = 1'b1;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Value shown in the LOAD cycle; a zero chase seed would show nothing, so it becomes bit0.
  always_comb begin
    init_val = pattern_q;
    case (mode_q)
      CHASE:   init_val = (pattern_q == '0) ? LED_BIT0 : pattern_q;
      BOUNCE:  init_val = LED_BIT0;
      BLINK:   init_val = pattern_q;
      STATIC:  init_val = pattern_q;
      default: init_val = pattern_q;
    endcase
  end

  // Pattern stepping.
  always_comb begin
    leds_d  = leds;
    dir_d   = dir_q;
    step_d  = 1'b0;
    shifted = '0;
    if (state_q == LOAD) begin
      leds_d = init_val;
      dir_d  = DIR_LEFT;
    end else if (step) begin
      step_d = 1'b1;
      case (mode_q)
        CHASE: leds_d = {leds[NUM_LEDS-2:0], leds[NUM_LEDS-1]};
        BOUNCE: begin
          // Turn around as soon as an endpoint is reached so it is shown only once.
          if (dir_q == DIR_LEFT) begin
            shifted = leds << 1;
            if (shifted[NUM_LEDS-1]) dir_d = DIR_RIGHT;
          end else begin
            shifted = leds >> 1;
            if (shifted[0]) dir_d = DIR_LEFT;
          end
          leds_d = shifted;
        end
        BLINK:   leds_d = (leds != '0) ? '0 : pattern_q;
        STATIC:  leds_d = leds;
        default: leds_d = leds;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge iCE_CLK or negedge iCE_RST_N) begin
    if (!iCE_RST_N) begin
      mode_q     <= CHASE;
      period_q   <= CNT_W'(DEFAULT_PERIOD);
      pattern_q  <= LED_BIT0;
      dir_q      <= DIR_LEFT;
      leds       <= '0;
      step_pulse <= 1'b0;
    end else begin
      if (accept) begin
        mode_q    <= mode_e'(cmd_mode);
        period_q  <= cmd_period;
        pattern_q <= cmd_pattern;
      end
      dir_q      <= dir_d;
      leds       <= leds_d;
      step_pulse <= step_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed self-checking bench for led_pattern_sequencer (DEFAULT_PERIOD=3).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: commands are only issued when cmd_ready is expected high.
module tb_led_pattern_sequencer;

  logic        iCE_CLK = 1'b0;
  logic        iCE_RST_N;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [31:0] cmd_period;
  logic [7:0]  cmd_pattern;
  logic        pause;
  logic [7:0]  leds;
  logic        step_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  led_pattern_sequencer #(
    .NUM_LEDS       (8),
    .CNT_W          (32),
    .DEFAULT_PERIOD (3)
  ) dut (
    .iCE_CLK     (iCE_CLK),
    .iCE_RST_N   (iCE_RST_N),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_period  (cmd_period),
    .cmd_pattern (cmd_pattern),
    .pause       (pause),
    .leds        (leds),
    .step_pulse  (step_pulse)
  );

  always #5 iCE_CLK = ~iCE_CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    else             n_pass++;
  endtask

  task automatic clk1();
    @(posedge iCE_CLK);
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [7:0] l_exp, input logic s_exp);
    clk1();
    chk({tag, "_leds"}, {24'd0, leds}, {24'd0, l_exp});
    chk({tag, "_step"}, {31'd0, step_pulse}, {31'd0, s_exp});
  endtask

  // Issue a command (accepted on the next edge); leds must not step during the accept cycle.
  task automatic send_cmd(input logic [1:0] m, input logic [31:0] p, input logic [7:0] pat,
                          input logic [7:0] prev);
    chk("rdy_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_mode    = m;
    cmd_period  = p;
    cmd_pattern = pat;
    cmd_valid   = 1'b1;
    clk1();
    cmd_valid = 1'b0;
    chk("rdy_in_load", {31'd0, cmd_ready}, 32'd0);
    chk("acc_leds", {24'd0, leds}, {24'd0, prev});
    chk("acc_step", {31'd0, step_pulse}, 32'd0);
  endtask

  logic [7:0] chase_tbl  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] bounce_tbl [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] blink_l    [6]  = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00};
  logic       blink_s    [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    iCE_RST_N   = 1'b0;
    cmd_valid   = 1'b0;
    cmd_mode    = 2'd0;
    cmd_period  = 32'd0;
    cmd_pattern = 8'd0;
    pause       = 1'b0;

    // 1. reset values, then default chase with period 3
    #23;
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_rdy", {31'd0, cmd_ready}, 32'd0);
    chk("rst_step", {31'd0, step_pulse}, 32'd0);
    iCE_RST_N = 1'b1;
    expect_cyc("t1_load", 8'h01, 1'b0);
    chk("t1_rdy", {31'd0, cmd_ready}, 32'd1);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 3; c++) expect_cyc("t1_hold", (s == 0) ? 8'h01 : chase_tbl[s-1], 1'b0);
      expect_cyc("t1_step", chase_tbl[s], 1'b1);
    end

    // 2. bounce, period 0: one step per clock, endpoints shown once
    send_cmd(2'd1, 32'd0, 8'hFF, 8'h01);
    expect_cyc("t2_load", 8'h01, 1'b0);
    for (int i = 0; i < 15; i++) expect_cyc("t2_bounce", bounce_tbl[i], 1'b1);

    // 3. blink A5, period 1 (accept collides with a period-0 tick: no step)
    send_cmd(2'd2, 32'd1, 8'hA5, 8'h02);
    expect_cyc("t3_load", 8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) expect_cyc("t3_blink", blink_l[i], blink_s[i]);

    // 4. static 3C, period 3
    send_cmd(2'd3, 32'd3, 8'h3C, 8'h00);
    expect_cyc("t4_load", 8'h3C, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) expect_cyc("t4_hold", 8'h3C, 1'b0);
      expect_cyc("t4_step", 8'h3C, 1'b1);
    end

    // 5. chase to 08, pause with 2 counts done, resume finishes only the remainder
    send_cmd(2'd0, 32'd3, 8'h01, 8'h3C);
    expect_cyc("t5_load", 8'h01, 1'b0);
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 3; c++) expect_cyc("t5_hold", (s == 0) ? 8'h01 : chase_tbl[s-1], 1'b0);
      expect_cyc("t5_step", chase_tbl[s], 1'b1);
    end
    expect_cyc("t5_pre", 8'h08, 1'b0);
    expect_cyc("t5_pre", 8'h08, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) expect_cyc("t5_paused", 8'h08, 1'b0);
    pause = 1'b0;
    expect_cyc("t5_resume", 8'h08, 1'b0);
    expect_cyc("t5_resume_step", 8'h10, 1'b1);

    // 6. command in the tick cycle of chase 0x10: command wins
    for (int c = 0; c < 3; c++) expect_cyc("t6_hold", 8'h10, 1'b0);
    send_cmd(2'd2, 32'd3, 8'hF0, 8'h10);
    expect_cyc("t6_load", 8'hF0, 1'b0);
    chk("t6_rdy", {31'd0, cmd_ready}, 32'd1);

    // held cmd_valid re-issues every 2 cycles
    cmd_mode    = 2'd3;
    cmd_period  = 32'd3;
    cmd_pattern = 8'h81;
    cmd_valid   = 1'b1;
    expect_cyc("t6_hold_acc1", 8'hF0, 1'b0);
    chk("t6_hold_rdy1", {31'd0, cmd_ready}, 32'd0);
    expect_cyc("t6_hold_load1", 8'h81, 1'b0);
    chk("t6_hold_rdy2", {31'd0, cmd_ready}, 32'd1);
    clk1();
    chk("t6_hold_rdy3", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    expect_cyc("t6_hold_load2", 8'h81, 1'b0);

    // command while paused: LOAD shows initial value (zero chase seed -> 01), then frozen
    pause = 1'b1;
    send_cmd(2'd0, 32'd0, 8'h00, 8'h81);
    expect_cyc("t7_load", 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) expect_cyc("t7_frozen", 8'h01, 1'b0);
    pause = 1'b0;
    expect_cyc("t7_run", 8'h02, 1'b1);
    expect_cyc("t7_run", 8'h04, 1'b1);

    // async reset mid-run, then default chase restarts
    #2;
    iCE_RST_N = 1'b0;
    #1;
    chk("t8_rst_leds", {24'd0, leds}, 32'd0);
    chk("t8_rst_step", {31'd0, step_pulse}, 32'd0);
    chk("t8_rst_rdy", {31'd0, cmd_ready}, 32'd0);
    #2;
    iCE_RST_N = 1'b1;
    expect_cyc("t8_load", 8'h01, 1'b0);
    chk("t8_rdy", {31'd0, cmd_ready}, 32'd1);
    for (int c = 0; c < 3; c++) expect_cyc("t8_hold", 8'h01, 1'b0);
    expect_cyc("t8_step", 8'h02, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
